// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands, checks framing/CRC7,
// hands them to a local handler and serialises the handler's 48-bit response back.
`timescale 1ns/1ps
module sd_card_cmd_responder #(
   parameter int NCR_CYCLES   = 2,
   parameter int RESP_TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sd_clk_i,
   input  logic        sd_cmd_i,
   output logic        sd_cmd_out_o,
   output logic        sd_cmd_oe_o,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg_o,
   input  logic        rsp_valid_i,
   output logic        rsp_ready_o,
   input  logic        rsp_none_i,
   input  logic [5:0]  rsp_index_i,
   input  logic [31:0] rsp_payload_i,
   output logic [7:0]  crc_err_cnt_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RX       = 3'd1,
      CHECK    = 3'd2,
      DELIVER  = 3'd3,
      WAIT_RSP = 3'd4,
      TX_WAIT  = 3'd5,
      TX       = 3'd6
   } state_t;

   localparam logic [7:0] NCR_MIN = 8'(NCR_CYCLES);
   localparam logic [7:0] RESP_TO = 8'(RESP_TIMEOUT);

   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0};
         if (fb) crc = crc ^ 7'h09;
         else    crc = crc;
      end
      return crc;
   endfunction

   // {clk, cmd} travel through one synchroniser so a sampled bit always matches its edge
   logic [1:0]  meta_q, meta_d, sync_q, sync_d;
   logic        clk_prev_q, clk_prev_d, rise_q, rise_d, fall_q, fall_d, cmd_bit_q, cmd_bit_d;
   state_t      state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [47:0] shift_q, shift_d, tx_q, tx_d;
   logic [7:0]  ncr_q, ncr_d, crc_err_q, crc_err_d;
   logic [5:0]  cmd_index_q, cmd_index_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic        cmd_valid_q, cmd_valid_d, rsp_ready_q, rsp_ready_d;
   logic        out_q, out_d, oe_q, oe_d;
   logic        frame_ok_s;

   assign frame_ok_s = (shift_q[47] == 1'b0) && shift_q[46] && shift_q[0] &&
                       (shift_q[7:1] == crc7(shift_q[47:8]));

   // Front end: synchroniser stages and registered edge strobes
   always_comb begin
      meta_d     = {sd_clk_i, sd_cmd_i};
      sync_d     = meta_q;
      clk_prev_d = sync_q[1];
      rise_d     = sync_q[1] & ~clk_prev_q;
      fall_d     = ~sync_q[1] & clk_prev_q;
      cmd_bit_d  = sync_q[0];
   end

   // Protocol FSM: next state and all registered outputs
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_cnt_d    = tx_cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      crc_err_d   = crc_err_q;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;
      cmd_valid_d = 1'b0;
      rsp_ready_d = 1'b0;
      out_d       = out_q;
      oe_d        = oe_q;
      if (rise_q && (ncr_q != 8'hFF)) ncr_d = ncr_q + 8'd1;
      else                            ncr_d = ncr_q;

      case (state_q)
         IDLE: begin
            out_d = 1'b1;
            oe_d  = 1'b0;
            if (rise_q && !cmd_bit_q) begin
               state_d   = RX;
               bit_cnt_d = 6'd1;
               shift_d   = 48'd0;
            end else begin
               state_d = IDLE;
            end
         end
         RX: begin
            if (rise_q) begin
               shift_d = {shift_q[46:0], cmd_bit_q};
               if (bit_cnt_q == 6'd47) begin
                  state_d   = CHECK;
                  bit_cnt_d = 6'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end else begin
               state_d = RX;
            end
         end
         CHECK: begin
            ncr_d = 8'd0;
            if (frame_ok_s) begin
               state_d     = DELIVER;
               cmd_valid_d = 1'b1;
               cmd_index_d = shift_q[45:40];
               cmd_arg_d   = shift_q[39:8];
            end else begin
               state_d = IDLE;
               if (crc_err_q != 8'hFF) crc_err_d = crc_err_q + 8'd1;
               else                    crc_err_d = crc_err_q;
            end
         end
         DELIVER: begin
            if (cmd_ready_i) begin
               state_d     = WAIT_RSP;
               rsp_ready_d = 1'b1;
            end else begin
               cmd_valid_d = 1'b1;
            end
         end
         WAIT_RSP: begin
            if (rsp_valid_i) begin
               if (rsp_none_i) begin
                  state_d = IDLE;
               end else begin
                  state_d = TX_WAIT;
                  tx_d    = {2'b00, rsp_index_i, rsp_payload_i,
                             crc7({2'b00, rsp_index_i, rsp_payload_i}), 1'b1};
               end
            end else if (ncr_q == RESP_TO) begin
               state_d = IDLE;
            end else begin
               rsp_ready_d = 1'b1;
            end
         end
         TX_WAIT: begin
            if (fall_q && (ncr_q >= NCR_MIN)) begin
               state_d  = TX;
               out_d    = tx_q[47];
               oe_d     = 1'b1;
               tx_d     = {tx_q[46:0], 1'b0};
               tx_cnt_d = 6'd1;
            end else begin
               state_d = TX_WAIT;
            end
         end
         TX: begin
            if (fall_q) begin
               if (tx_cnt_q == 6'd48) begin
                  state_d = IDLE;
                  out_d   = 1'b1;
                  oe_d    = 1'b0;
               end else begin
                  out_d    = tx_q[47];
                  tx_d     = {tx_q[46:0], 1'b0};
                  tx_cnt_d = tx_cnt_q + 6'd1;
               end
            end else begin
               state_d = TX;
            end
         end
         default: begin
            state_d = IDLE;
            out_d   = 1'b1;
            oe_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q      <= 2'b01;
         sync_q      <= 2'b01;
         clk_prev_q  <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         cmd_bit_q   <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 6'd0;
         tx_cnt_q    <= 6'd0;
         shift_q     <= 48'd0;
         tx_q        <= 48'd0;
         ncr_q       <= 8'd0;
         crc_err_q   <= 8'd0;
         cmd_index_q <= 6'd0;
         cmd_arg_q   <= 32'd0;
         cmd_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         out_q       <= 1'b1;
         oe_q        <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         clk_prev_q  <= clk_prev_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         cmd_bit_q   <= cmd_bit_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_cnt_q    <= tx_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         ncr_q       <= ncr_d;
         crc_err_q   <= crc_err_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
         cmd_valid_q <= cmd_valid_d;
         rsp_ready_q <= rsp_ready_d;
         out_q       <= out_d;
         oe_q        <= oe_d;
      end
   end

   assign sd_cmd_out_o  = out_q;
   assign sd_cmd_oe_o   = oe_q;
   assign cmd_valid_o   = cmd_valid_q;
   assign cmd_index_o   = cmd_index_q;
   assign cmd_arg_o     = cmd_arg_q;
   assign rsp_ready_o   = rsp_ready_q;
   assign crc_err_cnt_o = crc_err_q;

endmodule

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

Card-side responder for the SD bus CMD line, the counterpart to the SD host controller. It receives 48-bit host commands by sampling CMD on SD clock rising edges and validates framing and CRC7. Valid commands go to a local command handler over a valid/ready handshake; the handler's 48-bit response is then serialised back on falling edges. It sits in the card-emulation / loopback-verification path and runs entirely on the system clock, oversampling the host SD clock.

## Interface
- NCR_CYCLES, 2: minimum SD clock periods between command end bit and response start bit (≥2).
- RESP_TIMEOUT, 64: SD rising edges after command end bit within which a response must be accepted; 8-bit range, must exceed NCR_CYCLES.

- clk_i  in  1  system clock, ≥4× SD clock frequency
- rst_i  in  1  synchronous, active-high reset
- sd_clk_i  in  1  host SD clock (asynchronous, oversampled)
- sd_cmd_i  in  1  CMD line input
- sd_cmd_out_o  out  1  CMD drive value
- sd_cmd_oe_o  out  1  CMD output enable
- cmd_valid_o  out  1  decoded command available
- cmd_ready_i  in  1  handler accepts command
- cmd_index_o  out  6  command index
- cmd_arg_o  out  32  command argument
- rsp_valid_i  in  1  response offered
- rsp_ready_o  out  1  responder accepts response
- rsp_none_i  in  1  with rsp_valid_i: command takes no response
- rsp_index_i  in  6  response index field
- rsp_payload_i  in  32  response payload
- crc_err_cnt_o  out  8  saturating count of rejected frames

## Operation
- sd_clk_i and sd_cmd_i pass through the same 2-flop synchroniser, which keeps them aligned. Edge detect on synced clock gives one-cycle rise/fall strobes.
- States: IDLE, RX, CHECK, DELIVER, WAIT_RSP, TX_WAIT, TX.
- IDLE: rise strobe with CMD=0 → RX, bit count=1, shift in start bit.
- RX: shift CMD on each rise strobe; at 48 bits → CHECK.
- CHECK (1 cycle), frame valid iff:
  - bit46 (transmission) = 1;
  - bit0 (end) = 1;
  - bits 7:1 equal CRC7 (x^7+x^3+1, init 0, MSB-first) over bits 47:8.
  - Valid → DELIVER; invalid → IDLE, crc_err_cnt_o+1, saturating at 255.
- NCR counter: cleared in CHECK, increments on every rise strobe, saturates at 255.
- DELIVER: cmd_valid_o=1, index/arg stable until cmd_ready_i sampled high → WAIT_RSP. No timeout here.
- WAIT_RSP: rsp_ready_o=1.
  - On rsp_valid_i: rsp_none_i=1 → IDLE; otherwise latch frame {0,0,index,payload,CRC7,1} → TX_WAIT.
  - NCR counter = RESP_TIMEOUT with no response → IDLE, no error count.
- TX_WAIT: first fall strobe with NCR counter ≥ NCR_CYCLES → TX, drive bit47, oe=1.
- TX: each fall strobe drives next bit, MSB first. The fall strobe after the end bit sets oe=0, out=1 → IDLE.
- CMD activity outside IDLE/RX is ignored.

## Timing
- Reset values: sd_cmd_out_o=1, sd_cmd_oe_o=0, cmd_valid_o=0, rsp_ready_o=0, cmd_index_o=0, cmd_arg_o=0, crc_err_cnt_o=0, state IDLE. Reset mid-frame or mid-TX releases CMD on the next clk_i edge.
- Input to strobe latency: 3 clk_i (2 sync + edge register).
- Drive outputs are registered and update 1 clk_i after the fall strobe.
- cmd_valid_o asserts 1 clk_i after CHECK and deasserts the cycle after the handshake.
- A response accepted in the same cycle rsp_ready_o rises is valid.
- cmd_ready_i and rsp_valid_i are ignored outside DELIVER and WAIT_RSP respectively.
- Response bit period = one SD clock; oe is held exactly 48 SD periods.

## Test plan
- CMD0, bytes 40 00 00 00 00 95 → cmd_valid_o with index 0, arg 0. rsp_none_i → IDLE. oe stays 0 throughout.
- CMD8, bytes 48 00 00 01 AA 87 → index 8, arg 0x000001AA. Response index 8, payload 0x000001AA → CMD carries 08 00 00 01 AA 13. Start bit lands ≥2 SD periods after the command end bit.
- CMD17 with corrupted CRC byte 0x54 (correct 0x55) → no cmd_valid_o, crc_err_cnt_o=1. Repeat 300 times → counter holds at 255.
- Valid CMD55 (77 00 00 00 00 65), rsp_valid_i withheld → after 64 SD rising edges, rsp_ready_o drops and state returns to IDLE. Next CMD0 is decoded normally.
- cmd_ready_i held low for 500 SD clocks → cmd_valid_o, index and arg stay stable and no timeout occurs. Afterwards the response is sent immediately, since NCR is already met.
- rst_i asserted mid-response (bit 20) → next clk_i: oe=0, out=1, all handshakes low. A fresh command is then received correctly.
